ifetch_ctrl: RTL and testbench

- Fetch sequencer for the combinational, word-addressed instruction memory (5-bit word address, 32-bit instruction).
- Owns the program counter and drives the memory address.
- Registers each fetched instruction and its PC into a one-entry output buffer, handed to the decoder with a valid/ready handshake.
- Handles branch/jump redirects, misaligned-target faults, and detection of the self-loop halt idiom (jal x0,0 = 32'h0000006F).

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_outbuf.sv | 34 +++
 rtl/ifetch_ctrl.sv | 73 +++++++
 tb/tb_ifetch_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] HALT_INSTR = 32'h0000006F;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam int          PC_INC     = 4;

endpackage

// File: rtl/ifetch_outbuf.sv
// One-entry valid/ready output register between fetch and decode.
module ifetch_outbuf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Flush beats a fresh load; without either, an accepted entry drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction memory and feeds
// the decoder through a one-entry buffer; handles redirects, halt and fault.
module ifetch_ctrl #(
  parameter int              ADDR_W     = 5,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] HALT_INSTR = ifetch_pkg::HALT_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_instr,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [XLEN-1:0]   if_instr,
  output logic [XLEN-1:0]   if_pc,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       fetch_count
);

  import ifetch_pkg::*;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            cap;
  logic            accept;

  assign imem_addr = pc_q[ADDR_W+1:2];
  assign halted    = (state_q == HALT);
  assign fault     = (state_q == FAULT);
  assign cap       = (state_q == RUN) && !redirect_valid && (!if_valid || if_ready);
  assign accept    = if_valid && if_ready && !redirect_valid;

  // Redirects outrank captures; once faulted only reset gets us out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else if (redirect_valid && state_q != FAULT) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc_q    <= redirect_pc;
        state_q <= RUN;
      end else begin
        state_q <= FAULT;
      end
    end else if (cap) begin
      pc_q <= pc_q + XLEN'(PC_INC);
      if (imem_instr == HALT_INSTR) state_q <= HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_count <= '0;
    else if (accept) fetch_count <= fetch_count + 32'd1;
  end

  ifetch_outbuf #(.XLEN(XLEN)) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (cap),
    .flush      (redirect_valid),
    .ready      (if_ready),
    .load_instr (imem_instr),
    .load_pc    (pc_q),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the decoder should see, tracked per cycle.
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_next_pc;
  logic        m_halted;
  logic        m_fault;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  ifetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  task automatic model_reset();
    m_valid   = 1'b0;
    m_instr   = '0;
    m_pc      = '0;
    m_next_pc = '0;
    m_halted  = 1'b0;
    m_fault   = 1'b0;
    m_count   = '0;
  endtask

  task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] word;
    if (rv) begin
      if (!m_fault) begin
        m_valid = 1'b0;
        if (rpc % 4 == 0) begin
          m_next_pc = rpc;
          m_halted  = 1'b0;
        end else begin
          m_fault = 1'b1;
        end
      end
    end else begin
      if (m_valid && rdy) m_count = m_count + 1;
      if (!m_halted && !m_fault && (!m_valid || rdy)) begin
        word      = mem[(m_next_pc / 4) % 32];
        m_valid   = 1'b1;
        m_instr   = word;
        m_pc      = m_next_pc;
        m_next_pc = m_next_pc + 4;
        if (word == 32'h0000006F) m_halted = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_step(rdy, rv, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) mem[i] = 32'h00000013;
    mem[0] = 32'h003000B3;
    mem[1] = 32'h003000B3;
    mem[2] = 32'h003000B3;
    mem[3] = 32'h015A0933;
    mem[4] = 32'h017B08B3;
    mem[5] = 32'h0000006F;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (if_valid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got valid=%b halted=%b fault=%b expected 0/0/0", if_valid, halted, fault);
    end
    n_checks++;
    if (fetch_count !== 32'd0 || if_pc !== 32'd0 || if_instr !== 32'd0 || imem_addr !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got count=%h pc=%h instr=%h addr=%h expected zeros", fetch_count, if_pc, if_instr, imem_addr);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got valid=%b expected 0", if_valid);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, '0);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc[i] || if_instr !== mem[i]) begin
        n_fail++;
        $display("[TB] FAIL stream_%0d: got valid=%b pc=%h instr=%h expected 1 pc=%h instr=%h", i, if_valid, if_pc, if_instr, exp_pc[i], mem[i]);
      end
    end
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b0 || halted !== 1'b1 || fetch_count !== 32'd6) begin
      n_fail++;
      $display("[TB] FAIL stream_halt: got valid=%b halted=%b count=%0d expected 0/1/6", if_valid, halted, fetch_count);
    end
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b0 || halted !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL halt_no_capture: got valid=%b halted=%b expected 0/1", if_valid, halted);
    end
  endtask

  task automatic test_resume_from_halt();
    cycle(1'b1, 1'b1, 32'h0);
    n_checks++;
    if (halted !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL resume_bubble: got halted=%b valid=%b expected 0/0", halted, if_valid);
    end
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h003000B3) begin
      n_fail++;
      $display("[TB] FAIL resume_first: got valid=%b pc=%h instr=%h expected 1 pc=0 instr=003000b3", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] count_at_stall;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    count_at_stall = fetch_count;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h003000B3 || imem_addr !== 5'd3 || fetch_count !== count_at_stall) begin
        n_fail++;
        $display("[TB] FAIL stall_%0d: got valid=%b pc=%h instr=%h addr=%0d count=%0d expected 1 pc=8 instr=003000b3 addr=3 count=%0d",
                 i, if_valid, if_pc, if_instr, imem_addr, fetch_count, count_at_stall);
      end
    end
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'h015A0933) begin
      n_fail++;
      $display("[TB] FAIL stall_release: got valid=%b pc=%h instr=%h expected 1 pc=c instr=015a0933", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] count_before;
    cycle(1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
      n_fail++;
      $display("[TB] FAIL redirect_setup: got valid=%b pc=%h expected 1 pc=4", if_valid, if_pc);
    end
    count_before = m_count;
    cycle(1'b1, 1'b1, 32'h10);
    n_checks++;
    if (if_valid !== 1'b0 || fetch_count !== count_before) begin
      n_fail++;
      $display("[TB] FAIL redirect_flush: got valid=%b count=%0d expected 0 count=%0d", if_valid, fetch_count, count_before);
    end
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'h017B08B3 || fetch_count !== count_before) begin
      n_fail++;
      $display("[TB] FAIL redirect_target: got valid=%b pc=%h instr=%h count=%0d expected 1 pc=10 instr=017b08b3 count=%0d",
               if_valid, if_pc, if_instr, fetch_count, count_before);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 32'h7C);
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h7C || if_instr !== mem[31] || imem_addr !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL wrap_last: got valid=%b pc=%h instr=%h addr=%0d expected 1 pc=7c instr=%h addr=0", if_valid, if_pc, if_instr, imem_addr, mem[31]);
    end
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== mem[0]) begin
      n_fail++;
      $display("[TB] FAIL wrap_first: got valid=%b pc=%h instr=%h expected 1 pc=80 instr=%h", if_valid, if_pc, if_instr, mem[0]);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] count_before;
    logic [4:0]  addr_before;
    addr_before  = imem_addr;
    count_before = m_count;
    cycle(1'b1, 1'b1, 32'h6);
    n_checks++;
    if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== addr_before || fetch_count !== count_before) begin
      n_fail++;
      $display("[TB] FAIL misaligned: got fault=%b valid=%b addr=%0d count=%0d expected 1/0 addr=%0d count=%0d",
               fault, if_valid, imem_addr, fetch_count, addr_before, count_before);
    end
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0);
      n_checks++;
      if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== addr_before) begin
        n_fail++;
        $display("[TB] FAIL fault_sticky_%0d: got fault=%b valid=%b addr=%0d expected 1/0 addr=%0d", i, fault, if_valid, imem_addr, addr_before);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (fault !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL fault_reset: got fault=%b valid=%b addr=%0d expected 0/0/0", fault, if_valid, imem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_async_reset_stall();
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || fetch_count !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_stall: got valid=%b pc=%h count=%0d expected 1 pc=4 count=1", if_valid, if_pc, fetch_count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (if_valid !== 1'b0 || fetch_count !== 32'd0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got valid=%b count=%0d pc=%h instr=%h expected 0/0/0/0", if_valid, fetch_count, if_pc, if_instr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem[0]) begin
      n_fail++;
      $display("[TB] FAIL post_reset_fetch: got valid=%b pc=%h instr=%h expected 1 pc=0 instr=%h", if_valid, if_pc, if_instr, mem[0]);
    end
  endtask

  task automatic test_random();
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 9) == 0) ? 32'h0000006F : $urandom;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = {$urandom_range(0, 255), 2'b00};
      cycle(rdy, rv, rpc);
      n_checks++;
      if (if_valid !== m_valid || halted !== m_halted || fault !== m_fault || fetch_count !== m_count) begin
        n_fail++;
        $display("[TB] FAIL rand_ctrl_%0d: got valid=%b halted=%b fault=%b count=%0d expected %b/%b/%b count=%0d",
                 c, if_valid, halted, fault, fetch_count, m_valid, m_halted, m_fault, m_count);
      end
      n_checks++;
      if (imem_addr !== m_next_pc[6:2] || (m_valid && (if_pc !== m_pc || if_instr !== m_instr))) begin
        n_fail++;
        $display("[TB] FAIL rand_data_%0d: got addr=%0d pc=%h instr=%h expected addr=%0d pc=%h instr=%h",
                 c, imem_addr, if_pc, if_instr, m_next_pc[6:2], m_pc, m_instr);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    preload();
    model_reset();
    test_reset();
    test_stream();
    test_resume_from_halt();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_misaligned();
    test_async_reset_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
